// File: rtl/regfile_dump.sv
// Register-file dump engine: walks firstReg..lastReg through one regfile read
// port and streams (index, value) beats on a valid/ready interface, holding the core meanwhile.
module regfile_dump #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] firstReg,
    input  logic [ADDR_W-1:0] lastReg,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] rdData,
    output logic              dumpValid,
    input  logic              dumpReady,
    output logic [ADDR_W-1:0] dumpIdx,
    output logic [DATA_W-1:0] dumpData,
    output logic              busy,
    output logic              holdCore,
    output logic              done,
    output logic              rangeErr
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_last, w_last_nxt;
    logic [ADDR_W-1:0]   r_rdAddr, w_rdAddr_nxt;
    logic                r_valid, w_valid_nxt;
    logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_rerr, w_rerr_nxt;
    logic                w_range_ok;

    assign w_range_ok = (firstReg <= lastReg) && (32'(lastReg) < 32'(NUM_REGS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_rdAddr_nxt = r_rdAddr;
        w_valid_nxt  = r_valid;
        w_idx_nxt    = r_idx;
        w_data_nxt   = r_data;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_rerr_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_range_ok) begin
                        w_last_nxt   = lastReg;
                        w_rdAddr_nxt = firstReg;
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = S_READ;
                    end else begin
                        w_rerr_nxt = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (abort) begin
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_data_nxt  = rdData;
                    w_idx_nxt   = r_rdAddr;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // abort wins over a simultaneous acceptance
                if (abort) begin
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (dumpReady) begin
                    w_valid_nxt = 1'b0;
                    if (r_rdAddr == r_last) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_rdAddr_nxt = r_rdAddr + ADDR_W'(1);
                        w_state_nxt  = S_READ;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last   <= '0;
            r_rdAddr <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rerr   <= 1'b0;
        end else begin
            r_last   <= w_last_nxt;
            r_rdAddr <= w_rdAddr_nxt;
            r_valid  <= w_valid_nxt;
            r_idx    <= w_idx_nxt;
            r_data   <= w_data_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_rerr   <= w_rerr_nxt;
        end
    end

    assign rdAddr    = r_rdAddr;
    assign dumpValid = r_valid;
    assign dumpIdx   = r_idx;
    assign dumpData  = r_data;
    assign busy      = r_busy;
    assign holdCore  = r_busy;
    assign done      = r_done;
    assign rangeErr  = r_rerr;

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Read-side initiator for the 32x32 register file. On request, it walks a contiguous range of register indices through one regfile read port and streams each (index, value) pair out on a valid/ready interface. Typical consumers are a debug UART or a trace buffer.
- While a dump runs it asserts a core-hold so architectural state cannot change under it.
- Sits beside the datapath and owns the second read-port address mux when `busy`.

Parameters:
- ADDR_W, 5, register index width
- DATA_W, 32, register data width
- NUM_REGS, 32, number of architectural registers; valid indices are 0..NUM_REGS-1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle dump request; sampled only in IDLE
- abort  input  1  cancel the dump in progress
- firstReg  input  ADDR_W  first index to dump; sampled with start
- lastReg  input  ADDR_W  last index to dump, inclusive; sampled with start
- rdAddr  output  ADDR_W  drives the regfile readReg port
- rdData  input  DATA_W  regfile readData, combinational from rdAddr
- dumpValid  output  1  dumpIdx/dumpData valid
- dumpReady  input  1  consumer accepts the beat
- dumpIdx  output  ADDR_W  index of the current beat
- dumpData  output  DATA_W  value of the current beat
- busy  output  1  dump in progress
- holdCore  output  1  stall request to the core; equal to busy
- done  output  1  one-cycle pulse when the last beat is accepted
- rangeErr  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async, active-high): state=IDLE; rdAddr=0; dumpValid=0; dumpIdx=0; dumpData=0; busy=0; holdCore=0; done=0; rangeErr=0. Reset mid-dump drops the beat in flight and produces no done.
- States:
  - IDLE, READ, SEND.
  - done and rangeErr are registered pulses, high for exactly one cycle.
  - All outputs are registered.
- IDLE:
  - start=1 with firstReg<=lastReg and lastReg<NUM_REGS: latch lastReg, rdAddr<=firstReg, busy<=1, go to READ.
  - start=1 with firstReg>lastReg or lastReg>=NUM_REGS: rangeErr<=1, stay in IDLE, no beats.
  - start is ignored in any state other than IDLE.
- READ (one cycle): dumpData<=rdData, dumpIdx<=rdAddr, dumpValid<=1, go to SEND.
- SEND:
  - Hold dumpValid, dumpIdx and dumpData stable until dumpReady=1.
  - On an edge with dumpReady=1 and rdAddr==latched lastReg: dumpValid<=0, done<=1, busy<=0, go to IDLE.
  - On an edge with dumpReady=1 otherwise: dumpValid<=0, rdAddr<=rdAddr+1, go to READ.
- Timing:
  - First beat is valid 2 cycles after the start edge.
  - Peak throughput is 1 beat per 2 cycles.
  - Beat count is lastReg-firstReg+1.
  - rdAddr never wraps: the comparison against lastReg terminates the dump before rdAddr can exceed NUM_REGS-1.
- abort=1 in READ or SEND (takes priority over dumpReady): dumpValid<=0, busy<=0, go to IDLE, done stays 0. abort in IDLE has no effect.
- rdAddr holds its last value in IDLE.
- Register 0 is dumped like any other register; the regfile guarantees it reads 0.

Test Plan:
- Preload x1..x3 = 0x11111111, 0x22222222, 0x33333333; start with first=1, last=3, dumpReady tied 1 -> beats (1,0x11111111), (2,0x22222222), (3,0x33333333) at cycles 2, 4, 6 after start; done pulses in the cycle after the third acceptance; busy and holdCore high throughout.
- first=last=31 with x31=0xDEADBEEF -> exactly one beat (31,0xDEADBEEF), then done.
- first=5, last=2 -> rangeErr pulses once; busy, dumpValid and done stay 0.
- first=0, last=4 with dumpReady low for 5 cycles on beat 2 -> dumpIdx=2 and dumpData stay stable while stalled; no beat lost or duplicated; 5 beats total.
- abort asserted while beat idx 3 is pending (range 0..7) -> dumpValid=0 the next cycle, IDLE, no done; a following start with 0..0 works normally.
- reset asserted asynchronously mid-SEND -> all outputs 0 immediately without waiting for a clock edge; start pulsed during busy -> ignored, and the range in progress completes unchanged.
